// File: rtl/vga_pkg.sv
// Shared VGA constants and helpers for the layer compositor and its neighbours.
// Holds default colour depth, background index, 640x480 timing and the blink visibility rule.
package vga_pkg;

  localparam int DEF_COLOR_W = 4;
  localparam int RGB_W       = 3 * DEF_COLOR_W;
  localparam logic [RGB_W-1:0] RGB_BLACK = {RGB_W{1'b0}};
  localparam logic [3:0] BG_INDEX = 4'hF;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = 525;

  // A blinking layer shows only during the "on" half of the blink period.
  function automatic logic layer_visible(input logic en, input logic blink, input logic phase);
    return en & (~blink | phase);
  endfunction

endpackage

// File: rtl/vga_layer_prio.sv
// Combinational priority encoder: highest set index wins; idx is all-ones when
// nothing is set, which doubles as the background index downstream.
module vga_layer_prio
  import vga_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N) + 1
) (
  input  logic [N-1:0]     hit,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Ascending scan so the last (highest) hit overrides lower ones.
  always_comb begin
    valid = 1'b0;
    idx   = {IDX_W{1'b1}};
    for (int i = 0; i < N; i++) begin
      if (hit[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/vga_layer_mixer.sv
// N-input VGA layer compositor: frame-latched enables, per-layer blink, priority
// select over background, two-stage pipeline with sync delayed to match RGB.
module vga_layer_mixer
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS   = 8,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int BLINK_FRAMES = 30,
  parameter int PIPE_STAGES  = 2
) (
  input  logic                              ClkPort,
  input  logic                              Reset,
  input  logic                              pix_tick,
  input  logic                              frame_start,
  input  logic                              bright,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic [3*COLOR_W-1:0]              bg_rgb,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]             layer_hit,
  input  logic [NUM_LAYERS-1:0]             layer_en_req,
  input  logic [NUM_LAYERS-1:0]             layer_blink,
  output logic                              hSync,
  output logic                              vSync,
  output logic [COLOR_W-1:0]                vgaR,
  output logic [COLOR_W-1:0]                vgaG,
  output logic [COLOR_W-1:0]                vgaB,
  output logic [NUM_LAYERS-1:0]             active_mask,
  output logic [$clog2(NUM_LAYERS):0]       top_layer
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int IDX_W = $clog2(NUM_LAYERS) + 1;
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

  if (PIPE_STAGES != 2) begin : g_bad_pipe
    $error("vga_layer_mixer supports only PIPE_STAGES = 2");
  end

  logic [NUM_LAYERS-1:0]       mask_q, mask_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        phase_q, phase_d;
  logic [NUM_LAYERS-1:0]       vis_s;
  logic [NUM_LAYERS-1:0]       s1_hit_q, s1_hit_d;
  logic [NUM_LAYERS*PIX_W-1:0] s1_rgb_q, s1_rgb_d;
  logic [PIX_W-1:0]            s1_bg_q, s1_bg_d;
  logic                        s1_bright_q, s1_bright_d;
  logic                        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic                        prio_valid_s;
  logic [IDX_W-1:0]            prio_idx_s;
  logic [PIX_W-1:0]            sel_rgb_s;
  logic [PIX_W-1:0]            out_rgb_q, out_rgb_d;
  logic [IDX_W-1:0]            top_q, top_d;
  logic                        hs_q, hs_d, vs_q, vs_d;

  // Frame latch and blink counter; visibility uses the values that take effect this pixel.
  always_comb begin
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (pix_tick && frame_start) begin
      mask_d = layer_en_req;
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = {CNT_W{1'b0}};
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      mask_d = mask_q;
    end
    vis_s = {NUM_LAYERS{1'b0}};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      vis_s[i] = layer_visible(mask_d[i], layer_blink[i], phase_d);
    end
  end

  // Stage 1 capture of qualified coverage, colours, blanking and syncs.
  always_comb begin
    s1_hit_d    = s1_hit_q;
    s1_rgb_d    = s1_rgb_q;
    s1_bg_d     = s1_bg_q;
    s1_bright_d = s1_bright_q;
    s1_hs_d     = s1_hs_q;
    s1_vs_d     = s1_vs_q;
    if (pix_tick) begin
      s1_hit_d    = layer_hit & vis_s;
      s1_rgb_d    = layer_rgb;
      s1_bg_d     = bg_rgb;
      s1_bright_d = bright;
      s1_hs_d     = hsync_in;
      s1_vs_d     = vsync_in;
    end else begin
      s1_hit_d = s1_hit_q;
    end
  end

  vga_layer_prio #(
    .N     (NUM_LAYERS),
    .IDX_W (IDX_W)
  ) u_prio (
    .hit   (s1_hit_q),
    .valid (prio_valid_s),
    .idx   (prio_idx_s)
  );

  // Stage 2 colour mux and output register inputs; blanking forces black and background index.
  always_comb begin
    sel_rgb_s = s1_bg_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (prio_valid_s && (prio_idx_s == IDX_W'(i))) begin
        sel_rgb_s = s1_rgb_q[i*PIX_W +: PIX_W];
      end else begin
        sel_rgb_s = sel_rgb_s;
      end
    end
    out_rgb_d = out_rgb_q;
    top_d     = top_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    if (pix_tick) begin
      hs_d = s1_hs_q;
      vs_d = s1_vs_q;
      if (!s1_bright_q) begin
        out_rgb_d = {PIX_W{1'b0}};
        top_d     = {IDX_W{1'b1}};
      end else if (prio_valid_s) begin
        out_rgb_d = sel_rgb_s;
        top_d     = prio_idx_s;
      end else begin
        out_rgb_d = sel_rgb_s;
        top_d     = {IDX_W{1'b1}};
      end
    end else begin
      out_rgb_d = out_rgb_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      mask_q      <= {NUM_LAYERS{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      phase_q     <= 1'b0;
      s1_hit_q    <= {NUM_LAYERS{1'b0}};
      s1_rgb_q    <= {(NUM_LAYERS*PIX_W){1'b0}};
      s1_bg_q     <= {PIX_W{1'b0}};
      s1_bright_q <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      out_rgb_q   <= {PIX_W{1'b0}};
      top_q       <= {IDX_W{1'b1}};
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      s1_hit_q    <= s1_hit_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_bg_q     <= s1_bg_d;
      s1_bright_q <= s1_bright_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      out_rgb_q   <= out_rgb_d;
      top_q       <= top_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign vgaR        = out_rgb_q[PIX_W-1 -: COLOR_W];
  assign vgaG        = out_rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vgaB        = out_rgb_q[COLOR_W-1:0];
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign active_mask = mask_q;
  assign top_layer   = top_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: vector table for priority/blanking plus
// sequences for reset, frame latch, latency, sync alignment, blink and freeze.
module tb_vga_layer_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_tick, frame_start, bright, hsync_in, vsync_in;
  logic [11:0] bg_rgb;
  logic [95:0] layer_rgb;
  logic [7:0]  layer_hit, layer_en_req, layer_blink;
  logic        hSync, vSync;
  logic [3:0]  vgaR, vgaG, vgaB;
  logic [7:0]  active_mask;
  logic [3:0]  top_layer;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  hit;
    logic        bright;
    logic [11:0] rgb;
    logic [3:0]  top;
  } vec_t;

  vec_t vecs[8];

  vga_layer_mixer #(
    .NUM_LAYERS   (8),
    .COLOR_W      (4),
    .BLINK_FRAMES (2),
    .PIPE_STAGES  (2)
  ) dut (
    .ClkPort      (clk),
    .Reset        (rst),
    .pix_tick     (pix_tick),
    .frame_start  (frame_start),
    .bright       (bright),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .bg_rgb       (bg_rgb),
    .layer_rgb    (layer_rgb),
    .layer_hit    (layer_hit),
    .layer_en_req (layer_en_req),
    .layer_blink  (layer_blink),
    .hSync        (hSync),
    .vSync        (vSync),
    .vgaR         (vgaR),
    .vgaG         (vgaG),
    .vgaB         (vgaB),
    .active_mask  (active_mask),
    .top_layer    (top_layer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_pix(input string nm, input logic [11:0] exp_rgb, input logic [3:0] exp_top);
    chk({nm, "_rgb"}, {20'd0, vgaR, vgaG, vgaB}, {20'd0, exp_rgb});
    chk({nm, "_top"}, {28'd0, top_layer}, {28'd0, exp_top});
  endtask

  // One pixel: a single-clock pix_tick followed by three idle clocks.
  task automatic pix();
    @(negedge clk); pix_tick = 1'b1;
    @(negedge clk); pix_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [11:0] col;
    rst = 1'b1; pix_tick = 1'b0; frame_start = 1'b0; bright = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; bg_rgb = 12'hABC;
    layer_hit = 8'h00; layer_en_req = 8'h00; layer_blink = 8'h00;
    for (int i = 0; i < 8; i++) begin
      col = 12'(12'h111 * (i + 1));
      layer_rgb[i*12 +: 12] = col;
    end

    vecs[0] = '{8'h88, 1'b1, 12'h888, 4'd7};
    vecs[1] = '{8'h08, 1'b1, 12'h444, 4'd3};
    vecs[2] = '{8'h80, 1'b1, 12'h888, 4'd7};
    vecs[3] = '{8'h77, 1'b1, 12'hABC, 4'hF};
    vecs[4] = '{8'h00, 1'b1, 12'hABC, 4'hF};
    vecs[5] = '{8'hFF, 1'b0, 12'h000, 4'hF};
    vecs[6] = '{8'h0F, 1'b1, 12'h444, 4'd3};
    vecs[7] = '{8'h00, 1'b0, 12'h000, 4'hF};

    // Power-on reset state
    repeat (5) @(negedge clk);
    chk_pix("por", 12'h000, 4'hF);
    chk("por_hs", {31'd0, hSync}, 32'd1);
    chk("por_vs", {31'd0, vSync}, 32'd1);
    chk("por_mask", {24'd0, active_mask}, 32'd0);
    rst = 1'b0;

    // Enables requested mid-frame only apply from the next frame_start
    layer_en_req = 8'h05; layer_hit = 8'hFF;
    pix(); pix();
    chk_pix("midreq", 12'hABC, 4'hF);
    chk("midreq_mask", {24'd0, active_mask}, 32'd0);
    frame_start = 1'b1; pix(); frame_start = 1'b0;
    chk("latch_mask", {24'd0, active_mask}, 32'h05);
    pix();
    chk_pix("latch", 12'h333, 4'd2);

    // Latch layers 7 and 3, then run the vector table
    layer_en_req = 8'h88;
    frame_start = 1'b1; pix(); frame_start = 1'b0;
    chk("mask88", {24'd0, active_mask}, 32'h88);
    for (int i = 0; i < 8; i++) begin
      layer_hit = vecs[i].hit; bright = vecs[i].bright;
      pix(); pix();
      chk_pix($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].top);
    end

    // Losing the top layer shows the next one exactly two ticks later
    layer_hit = 8'h88; bright = 1'b1;
    pix(); pix();
    chk_pix("prio_both", 12'h888, 4'd7);
    layer_hit = 8'h08;
    pix();
    chk_pix("prio_lat1", 12'h888, 4'd7);
    pix();
    chk_pix("prio_lat2", 12'h444, 4'd3);

    // Blanked pixel with a sync pulse: both emerge together two ticks later
    hsync_in = 1'b0; vsync_in = 1'b0; bright = 1'b0; layer_hit = 8'h01;
    pix();
    chk("sync_t1_hs", {31'd0, hSync}, 32'd1);
    chk_pix("sync_t1", 12'h444, 4'd3);
    hsync_in = 1'b1; vsync_in = 1'b1; bright = 1'b1; layer_hit = 8'h08;
    pix();
    chk("sync_t2_hs", {31'd0, hSync}, 32'd0);
    chk("sync_t2_vs", {31'd0, vSync}, 32'd0);
    chk_pix("sync_t2", 12'h000, 4'hF);
    pix();
    chk("sync_t3_hs", {31'd0, hSync}, 32'd1);
    chk_pix("sync_t3", 12'h444, 4'd3);

    // Reset asserted mid-line, held while pix_tick keeps running
    rst = 1'b1;
    @(negedge clk);
    chk_pix("rst_mid", 12'h000, 4'hF);
    chk("rst_mid_hs", {31'd0, hSync}, 32'd1);
    chk("rst_mid_vs", {31'd0, vSync}, 32'd1);
    chk("rst_mid_mask", {24'd0, active_mask}, 32'd0);
    pix(); pix();
    @(negedge clk);
    chk_pix("rst_hold", 12'h000, 4'hF);
    chk("rst_hold_mask", {24'd0, active_mask}, 32'd0);
    rst = 1'b0;

    // Blink with BLINK_FRAMES=2: frame 0 is the partial frame after reset
    layer_en_req = 8'h02; layer_blink = 8'h02; layer_hit = 8'h02;
    pix(); pix();
    chk_pix("blink_f0", 12'hABC, 4'hF);
    chk("blink_f0_mask", {24'd0, active_mask}, 32'd0);
    for (int f = 1; f <= 5; f++) begin
      frame_start = 1'b1; pix(); frame_start = 1'b0;
      pix();
      if (f == 2 || f == 3) chk_pix($sformatf("blink_f%0d", f), 12'h222, 4'd1);
      else                  chk_pix($sformatf("blink_f%0d", f), 12'hABC, 4'hF);
      if (f == 1) begin
        // Freeze: no pix_tick for 20 clocks while inputs churn
        frame_start = 1'b1; layer_hit = 8'h00; hsync_in = 1'b0; layer_en_req = 8'hFF;
        repeat (20) @(negedge clk);
        chk_pix("freeze", 12'hABC, 4'hF);
        chk("freeze_hs", {31'd0, hSync}, 32'd1);
        chk("freeze_mask", {24'd0, active_mask}, 32'h02);
        frame_start = 1'b0; layer_hit = 8'h02; hsync_in = 1'b1; layer_en_req = 8'h02;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
